// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for the serial adder/subtractor.
// Master drives the request, slave returns the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock,
// carry kept in a register between digits.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT:0]   d_add;
  logic             accept;
  logic             last;
  int               base;

  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == CW'(STEPS - 1));
  assign base   = int'(cnt) * DIGIT;

  always_comb begin
    a_d   = a_q[base +: DIGIT];
    b_d   = b_q[base +: DIGIT];
    d_add = {1'b0, a_d} + {1'b0, b_d}
          + (DIGIT + 1)'(carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction runs as a + ~b + ~borrow_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.cin ^ bus.sub;
      cnt   <= '0;
      sum_q <= '0;
    end else if (state == RUN) begin
      sum_q[base +: DIGIT] <= d_add[DIGIT-1:0];
      carry <= d_add[DIGIT];
      if (last) begin
        cout_q <= d_add[DIGIT];
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
               && (d_add[DIGIT-1] != a_q[WIDTH-1]);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8-bit/1-bit-digit and
// 4-bit/2-bit-digit instances against an arithmetic model.
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   e_s;
  bit   e_co;
  bit   e_ov;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if8.slave)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(
    input int w, input int a, input int b,
    input bit s, input bit c,
    output int rs, output bit co, output bit ov);
    int m, t, sa, sb, st;
    m = 1 << w;
    if (s) begin
      t  = a - b - int'(c);
      co = (t >= 0);
    end else begin
      t  = a + b + int'(c);
      co = (t >= m);
    end
    rs = (t + 2 * m) % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    st = s ? sa - sb - int'(c) : sa + sb + int'(c);
    ov = (st < -(m / 2)) || (st >= m / 2);
  endfunction

  // Caller is at a negedge; returns at the done negedge.
  task automatic run8(input int a, input int b,
                      input bit s, input bit c,
                      input bit glitch);
    model(8, a, b, s, c, e_s, e_co, e_ov);
    if8.a     = 8'(a);
    if8.b     = 8'(b);
    if8.sub   = s;
    if8.cin   = c;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    if8.sub   = 1'($urandom);
    if8.cin   = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy8", if8.busy, 1);
      chk("nodone8", if8.done, 0);
      if (glitch && i == 2) begin
        if8.start = 1'b1;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.sub   = ~s;
      end
      if (glitch && i == 3) if8.start = 1'b0;
    end
    @(negedge clk);
    chk("done8", if8.done, 1);
    chk("idle8", if8.busy, 0);
    chk("sum8", if8.sum, e_s);
    chk("cout8", if8.cout, e_co);
    chk("ovf8", if8.overflow, e_ov);
  endtask

  task automatic run4(input int a, input int b,
                      input bit s, input bit c);
    model(4, a, b, s, c, e_s, e_co, e_ov);
    if4.a     = 4'(a);
    if4.b     = 4'(b);
    if4.sub   = s;
    if4.cin   = c;
    if4.start = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    if4.a     = 4'($urandom);
    if4.b     = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("busy4", if4.busy, 1);
      chk("nodone4", if4.done, 0);
    end
    @(negedge clk);
    chk("done4", if4.done, 1);
    chk("idle4", if4.busy, 0);
    chk("sum4", if4.sum, e_s);
    chk("cout4", if4.cout, e_co);
    chk("ovf4", if4.overflow, e_ov);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if8.start = 1'b0;
    if8.sub   = 1'b0;
    if8.cin   = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if4.start = 1'b0;
    if4.sub   = 1'b0;
    if4.cin   = 1'b0;
    if4.a     = '0;
    if4.b     = '0;

    #12;
    chk("rst_busy", if8.busy, 0);
    chk("rst_done", if8.done, 0);
    chk("rst_sum", if8.sum, 0);
    chk("rst_cout", if8.cout, 0);
    chk("rst_ovf", if8.overflow, 0);
    chk("rst_sum4", if4.sum, 0);
    chk("rst_done4", if4.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("v1_sum", if8.sum, 8'h96);
    chk("v1_cout", if8.cout, 0);
    chk("v1_ovf", if8.overflow, 1);
    @(negedge clk);
    chk("hold_done", if8.done, 0);
    chk("hold_sum", if8.sum, 8'h96);

    run8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("v2_sum", if8.sum, 8'h01);
    chk("v2_cout", if8.cout, 1);
    chk("v2_ovf", if8.overflow, 0);
    run8(8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("v3_sum", if8.sum, 8'h0F);
    chk("v3_cout", if8.cout, 1);
    run8(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("v4_sum", if8.sum, 8'hFF);
    chk("v4_cout", if8.cout, 0);
    chk("v4_ovf", if8.overflow, 0);
    run8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("v5_sum", if8.sum, 8'h7F);
    chk("v5_ovf", if8.overflow, 1);

    run8(8'h21, 8'h42, 1'b0, 1'b0, 1'b1);
    chk("glitch_sum", if8.sum, 8'h63);

    for (int n = 0; n < 40; n++) begin
      run8(int'($urandom_range(255)),
           int'($urandom_range(255)),
           1'($urandom), 1'($urandom), 1'b0);
      if (n % 4 == 0) @(negedge clk);
    end

    @(negedge clk);
    if8.a     = 8'hFF;
    if8.b     = 8'h00;
    if8.sub   = 1'b0;
    if8.cin   = 1'b0;
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", if8.busy, 0);
    chk("arst_done", if8.done, 0);
    chk("arst_sum", if8.sum, 0);
    chk("arst_cout", if8.cout, 0);
    chk("arst_ovf", if8.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_nodone", if8.done, 0);
    end
    run8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("post_rst_sum", if8.sum, 8'h80);
    chk("post_rst_ovf", if8.overflow, 1);

    @(negedge clk);
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            run4(a, b, 1'(s), 1'(c));

    @(negedge clk);
    @(negedge clk);
    model(4, 9, 5, 1'b1, 1'b1, e_s, e_co, e_ov);
    if4.a     = 4'd9;
    if4.b     = 4'd5;
    if4.sub   = 1'b1;
    if4.cin   = 1'b1;
    if4.start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("b2b_done", if4.done, (i % 3 == 0) ? 1 : 0);
      if (i % 3 == 0) chk("b2b_sum", if4.sum, e_s);
    end
    if4.start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", if4.busy, 0);
    chk("b2b_end", if4.done, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
